// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Input front end for the stopwatch. Each raw pushbutton channel goes through
// a two-flop synchroniser, a consecutive-sample debouncer, registered edge
// detection and, on channels selected by REPEAT_EN, long-press / auto-repeat
// generation.
//
// Parameters
//   N_BTN          number of independent button channels
//   DB_CYCLES      consecutive disagreeing samples needed to flip the level (>=2)
//   HOLD_CYCLES    cycles after the press pulse until long-press is reported (>=2)
//   REPEAT_CYCLES  auto-repeat period once held (>=2)
//   REPEAT_EN      per-channel enable for btn_held / btn_repeat
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high; clears every flop
//   btn_in       raw, asynchronous, bouncing buttons (active-high)
//   btn_level    debounced level
//   btn_press    one-cycle pulse on each accepted 0->1 transition
//   btn_release  one-cycle pulse on each accepted 1->0 transition
//   btn_held     high while an enabled channel has been held >= HOLD_CYCLES
//   btn_repeat   one-cycle auto-repeat pulses on held channels
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int               N_BTN         = 6,
  parameter int               DB_CYCLES     = 2000000,
  parameter int               HOLD_CYCLES   = 100000000,
  parameter int               REPEAT_CYCLES = 20000000,
  parameter logic [N_BTN-1:0] REPEAT_EN     = 6'b000010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_held,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DB_W     = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W     = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  // Terminal counts: the event fires on the edge where the counter would
  // otherwise step from *_LAST to the full cycle count.
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } hold_state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // ---- synchroniser: raw input straight into two flops, no logic between
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_in[i];
        sync2_q <= sync1_q;
      end
    end

    // ---- debounce and edge detection
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    always_comb begin
      db_cnt_d  = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      // Any agreeing sample leaves db_cnt_d at 0, restarting the count.
      if (sync2_q != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d   = ~level_q;
          press_d   = ~level_q;
          release_d = level_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

    // ---- long press / auto-repeat
    if (REPEAT_EN[i]) begin : g_rep

      hold_state_e     state_q, state_d;
      logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
      logic            held_q, held_d;
      logic            repeat_q, repeat_d;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= '0;
          held_q     <= 1'b0;
          repeat_q   <= 1'b0;
        end else begin
          state_q    <= state_d;
          hold_cnt_q <= hold_cnt_d;
          held_q     <= held_d;
          repeat_q   <= repeat_d;
        end
      end

      // Decisions look at level_d so that held drops, and any repeat due on
      // the same edge is suppressed, in the very cycle the release pulse
      // shows. The counter starts on the edge after the press pulse edge, so
      // held appears exactly HOLD_CYCLES cycles after btn_press.
      always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        held_d     = held_q;
        repeat_d   = 1'b0;
        unique case (state_q)
          ST_IDLE: begin
            hold_cnt_d = '0;
            held_d     = 1'b0;
            if (level_d) state_d = ST_PRESSED;
          end
          ST_PRESSED: begin
            if (!level_d) begin
              state_d    = ST_IDLE;
              hold_cnt_d = '0;
              held_d     = 1'b0;
            end else if (hold_cnt_q == HOLD_LAST) begin
              state_d    = ST_HELD;
              hold_cnt_d = '0;
              held_d     = 1'b1;
              repeat_d   = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
          end
          ST_HELD: begin
            if (!level_d) begin
              state_d    = ST_IDLE;
              hold_cnt_d = '0;
              held_d     = 1'b0;
            end else if (hold_cnt_q == REP_LAST) begin
              hold_cnt_d = '0;
              repeat_d   = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
          end
          default: begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            held_d     = 1'b0;
          end
        endcase
      end

      assign btn_held[i]   = held_q;
      assign btn_repeat[i] = repeat_q;

    end else begin : g_norep
      assign btn_held[i]   = 1'b0;
      assign btn_repeat[i] = 1'b0;
    end

  end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Drives directed and random button patterns into btn_conditioner and compares
// every output, every cycle, against a reference model that works from sample
// history and elapsed time since the press rather than from counters.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int               N   = 6;
  localparam int               DB  = 4;
  localparam int               H   = 20;
  localparam int               R   = 6;
  localparam logic [N-1:0]     MSK = 6'b000010;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_held, btn_repeat;

  btn_conditioner #(
    .N_BTN        (N),
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R),
    .REPEAT_EN    (MSK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_held   (btn_held),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int           k;                 // clock edges since reset release
  logic [N-1:0] hist[$];           // btn_in sampled at edge 1, 2, ...
  int           press_edge[N];
  logic [N-1:0] m_level, m_press, m_release, m_held, m_repeat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
  endtask

  // The synchronised value used at edge e is the raw sample taken two edges
  // earlier; everything before reset release reads as 0.
  function automatic logic sync_at(int e, int ch);
    if (e - 2 < 1) return 1'b0;
    return hist[e - 3][ch];
  endfunction

  task automatic model_reset();
    k = 0;
    hist.delete();
    m_level = '0; m_press = '0; m_release = '0; m_held = '0; m_repeat = '0;
    for (int i = 0; i < N; i++) press_edge[i] = 0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit all_diff;
      int d;
      m_press[i]   = 1'b0;
      m_release[i] = 1'b0;
      m_repeat[i]  = 1'b0;
      // Level flips once DB consecutive synchronised samples all disagree.
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (k - j < 1 || sync_at(k - j, i) == m_level[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) begin
          m_press[i]    = 1'b1;
          press_edge[i] = k;
        end else begin
          m_release[i] = 1'b1;
        end
      end
      m_held[i] = 1'b0;
      if (MSK[i] && m_level[i]) begin
        d = k - press_edge[i];
        m_held[i]   = (d >= H);
        m_repeat[i] = (d >= H) && ((d - H) % R == 0);
      end
    end
  endtask

  task automatic check_all();
    chk("level",   btn_level,   m_level);
    chk("press",   btn_press,   m_press);
    chk("release", btn_release, m_release);
    chk("held",    btn_held,    m_held);
    chk("repeat",  btn_repeat,  m_repeat);
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    hist.push_back(btn_in);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic obs_bit(int sel, int ch);
    case (sel)
      0:       return btn_press[ch];
      1:       return btn_release[ch];
      2:       return btn_held[ch];
      default: return btn_repeat[ch];
    endcase
  endfunction

  // Runs n cycles and reports the edge of the first occurrence (-1 if none)
  // and the number of cycles the selected output was high.
  task automatic run_watch(input int n, input int sel, input int ch,
                           output int first_at, output int count);
    first_at = -1;
    count    = 0;
    for (int c = 0; c < n; c++) begin
      step();
      if (obs_bit(sel, ch)) begin
        if (first_at < 0) first_at = k;
        count++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"},   btn_level,   '0);
    chk({tag, "_press"},   btn_press,   '0);
    chk({tag, "_release"}, btn_release, '0);
    chk({tag, "_held"},    btn_held,    '0);
    chk({tag, "_repeat"},  btn_repeat,  '0);
  endtask

  initial begin
    int rise_k, at, cnt, at2, cnt2, press_k, held_k;
    int rep_k[$];
    logic [N-1:0] v;

    // ---- reset state
    model_reset();
    #1 reset = 1'b1;
    #2 check_zero("rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) step();

    // ---- clean press / release on channel 0
    rise_k = k; btn_in[0] = 1'b1;
    run_watch(12, 0, 0, at, cnt);
    chk("press0_latency", at - rise_k, DB + 2);
    chk("press0_count", cnt, 1);
    rise_k = k; btn_in[0] = 1'b0;
    run_watch(12, 1, 0, at, cnt);
    chk("release0_latency", at - rise_k, DB + 2);

    // ---- bounce rejection on channel 2
    for (int b = 0; b < 2; b++) begin
      btn_in[2] = 1'b1; run_watch(3, 0, 2, at, cnt); chk("bounce_hi_press", cnt, 0);
      btn_in[2] = 1'b0; run_watch(3, 0, 2, at, cnt); chk("bounce_lo_press", cnt, 0);
    end
    rise_k = k; btn_in[2] = 1'b1;
    run_watch(14, 0, 2, at, cnt);
    chk("bounce_press_latency", at - rise_k, DB + 2);
    chk("bounce_press_count", cnt, 1);
    btn_in[2] = 1'b0;
    for (int c = 0; c < 10; c++) step();

    // ---- long press with auto-repeat on channel 1
    rise_k = k; btn_in[1] = 1'b1;
    press_k = -1; held_k = -1; rep_k.delete();
    for (int c = 0; c < 50; c++) begin
      step();
      if (btn_press[1]  && press_k < 0) press_k = k;
      if (btn_held[1]   && held_k  < 0) held_k  = k;
      if (btn_repeat[1]) rep_k.push_back(k);
    end
    chk("long_press_latency", press_k - rise_k, DB + 2);
    chk("long_held_offset", held_k - press_k, H);
    chk("long_first_repeat", (rep_k.size() > 0) ? rep_k[0] : -1, held_k);
    chk("long_repeat_period", (rep_k.size() > 1) ? rep_k[1] - rep_k[0] : -1, R);
    btn_in[1] = 1'b0;
    run_watch(12, 3, 1, at, cnt);
    chk("long_no_repeat_after_release", cnt, 0);

    // ---- repeat mask: channel 0 held long never reports held/repeat
    btn_in[0] = 1'b1;
    run_watch(50, 2, 0, at, cnt);
    chk("mask_held0", cnt, 0);
    btn_in[0] = 1'b0;
    for (int c = 0; c < 10; c++) step();

    // ---- simultaneous presses on channels 3 and 4
    rise_k = k; btn_in[3] = 1'b1; btn_in[4] = 1'b1;
    press_k = -1; held_k = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (btn_press[3] && press_k < 0) press_k = k;
      if (btn_press[4] && held_k  < 0) held_k  = k;
    end
    chk("simul_press3_latency", press_k - rise_k, DB + 2);
    chk("simul_same_cycle", held_k, press_k);
    btn_in[3] = 1'b0; btn_in[4] = 1'b0;
    for (int c = 0; c < 10; c++) step();

    // ---- random activity; channel 1 toggles rarely so long presses occur
    for (int c = 0; c < 600; c++) begin
      v = btn_in;
      for (int i = 0; i < N; i++) begin
        if (i == 1) begin
          if ($urandom_range(0, 39) == 0) v[i] = ~v[i];
        end else if ($urandom_range(0, 7) == 0) begin
          v[i] = ~v[i];
        end
      end
      btn_in = v;
      step();
    end
    btn_in = '0;
    for (int c = 0; c < 15; c++) step();

    // ---- reset in the middle of a long press
    btn_in[1] = 1'b1;
    run_watch(60, 2, 1, at, cnt);
    chk("pre_reset_held_reached", (at > 0) ? 1 : 0, 1);
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    rise_k = k;
    press_k = -1; held_k = -1;
    for (int c = 0; c < 35; c++) begin
      step();
      if (btn_press[1] && press_k < 0) press_k = k;
      if (btn_held[1]  && held_k  < 0) held_k  = k;
    end
    chk("post_reset_press_latency", press_k - rise_k, DB + 2);
    chk("post_reset_held_offset", held_k - press_k, H);
    btn_in[1] = 1'b0;
    run_watch(12, 1, 1, at2, cnt2);
    chk("post_reset_release_count", cnt2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
